// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Turns memory-busy,
//   load-use, redirect and halt events into freeze/clear controls for the PC
//   and the F/D, D/X, X/M and M/W pipeline registers. It also keeps saturating
//   stall and flush performance counters.
// Ports
//   clk, global_rst          clock, synchronous active-high reset
//   imem_stall, dmem_stall   instruction / data memory busy
//   load_use_ID              load-use hazard detected in ID
//   redirect_EX              taken branch/jump resolved in EX
//   halt_ID, halt_WB         HALT decoded in ID / retiring in WB
//   freeze_PC..freeze_MW     hold PC / pipeline registers
//   clr_FD, clr_DX           inject NOP / bubble
//   halted                   pipeline stopped after HALT retired
//   state_dbg                current FSM state encoding
//   stall_cnt, flush_cnt     saturating perf counters
// Control outputs are combinational from state and inputs; the counters are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             load_use_ID,
  input  logic             redirect_EX,
  input  logic             halt_ID,
  input  logic             halt_WB,
  output logic             freeze_PC,
  output logic             freeze_FD,
  output logic             freeze_DX,
  output logic             freeze_XM,
  output logic             freeze_MW,
  output logic             clr_FD,
  output logic             clr_DX,
  output logic             halted,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    IMISS  = 3'd1,
    DMISS  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   redir_pend, redir_pend_nxt;
  logic   stall_ev, flush_ev;

  // State, pending-redirect and perf-counter registers
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state      <= RUN;
      redir_pend <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      redir_pend <= redir_pend_nxt;
      if (stall_ev && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Next-state and hazard control outputs
  always_comb begin
    state_nxt      = state;
    redir_pend_nxt = redir_pend;
    freeze_PC      = 1'b0;
    freeze_FD      = 1'b0;
    freeze_DX      = 1'b0;
    freeze_XM      = 1'b0;
    freeze_MW      = 1'b0;
    clr_FD         = 1'b0;
    clr_DX         = 1'b0;
    halted         = 1'b0;
    flush_ev       = 1'b0;

    if (global_rst) begin
      clr_FD = 1'b1;
      clr_DX = 1'b1;
    end else if (state == HALTED) begin
      freeze_PC = 1'b1;
      freeze_FD = 1'b1;
      freeze_DX = 1'b1;
      freeze_XM = 1'b1;
      freeze_MW = 1'b1;
      halted    = 1'b1;
    end else begin
      if (dmem_stall) begin
        freeze_PC = 1'b1;
        freeze_FD = 1'b1;
        freeze_DX = 1'b1;
        freeze_XM = 1'b1;
        freeze_MW = 1'b1;
      end else if (redirect_EX) begin
        clr_FD   = 1'b1;
        clr_DX   = 1'b1;
        flush_ev = 1'b1;
      end else if (state == DRAIN) begin
        // Only NOPs are fetched behind the HALT while older work drains
        freeze_PC = 1'b1;
        clr_FD    = 1'b1;
      end else if (load_use_ID) begin
        freeze_PC = 1'b1;
        freeze_FD = 1'b1;
        clr_DX    = 1'b1;
      end else if (imem_stall || halt_ID) begin
        freeze_PC = 1'b1;
        clr_FD    = 1'b1;
      end

      // The wrong-path fetch in flight during a redirect is discarded,
      // including on the cycle the miss finally returns
      if (!dmem_stall && redir_pend)
        clr_FD = 1'b1;

      // Clear always wins over freeze on the same register
      if (clr_FD) freeze_FD = 1'b0;
      if (clr_DX) freeze_DX = 1'b0;

      if (!dmem_stall) begin
        if (redirect_EX && imem_stall)
          redir_pend_nxt = 1'b1;
        else if (!imem_stall)
          redir_pend_nxt = 1'b0;
      end

      if (halt_WB && !dmem_stall)       state_nxt = HALTED;
      else if (dmem_stall)              state_nxt = DMISS;
      else if (redirect_EX)             state_nxt = imem_stall ? IMISS : RUN;
      else if (state == DRAIN)          state_nxt = DRAIN;
      else if (load_use_ID)             state_nxt = imem_stall ? IMISS : RUN;
      else if (halt_ID)                 state_nxt = DRAIN;
      else if (imem_stall)              state_nxt = IMISS;
      else                              state_nxt = RUN;
    end
  end

  assign stall_ev  = freeze_PC && !global_rst && (state != HALTED);
  assign state_dbg = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed checks of the hazard controller with hand-computed expectations,
//   using 4-bit counters so that saturation is reachable.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             global_rst;
  logic             imem_stall, dmem_stall, load_use_ID, redirect_EX, halt_ID, halt_WB;
  logic             freeze_PC, freeze_FD, freeze_DX, freeze_XM, freeze_MW;
  logic             clr_FD, clr_DX, halted;
  logic [2:0]       state_dbg;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .global_rst  (global_rst),
    .imem_stall  (imem_stall),
    .dmem_stall  (dmem_stall),
    .load_use_ID (load_use_ID),
    .redirect_EX (redirect_EX),
    .halt_ID     (halt_ID),
    .halt_WB     (halt_WB),
    .freeze_PC   (freeze_PC),
    .freeze_FD   (freeze_FD),
    .freeze_DX   (freeze_DX),
    .freeze_XM   (freeze_XM),
    .freeze_MW   (freeze_MW),
    .clr_FD      (clr_FD),
    .clr_DX      (clr_DX),
    .halted      (halted),
    .state_dbg   (state_dbg),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pack freezes {PC,FD,DX,XM,MW} and clears {FD,DX} into one word
  function automatic logic [31:0] ctl();
    return 32'({freeze_PC, freeze_FD, freeze_DX, freeze_XM, freeze_MW, clr_FD, clr_DX});
  endfunction

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before sampling
  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    global_rst = 1'b1;
    cyc();
    cyc();
    global_rst = 1'b0;
  endtask

  initial begin
    global_rst  = 1'b1;
    imem_stall  = 1'b0;
    dmem_stall  = 1'b0;
    load_use_ID = 1'b0;
    redirect_EX = 1'b0;
    halt_ID     = 1'b0;
    halt_WB     = 1'b0;

    // Reset: no freezes, both clears asserted
    settle();
    check("rst_ctl", ctl(), 32'b00000_11);
    cyc();
    check("rst_ctl2", ctl(), 32'b00000_11);
    cyc();
    global_rst = 1'b0;
    settle();
    check("post_rst_state", 32'(state_dbg), 32'd0);
    check("post_rst_stall", 32'(stall_cnt), 32'd0);
    check("post_rst_flush", 32'(flush_cnt), 32'd0);
    check("post_rst_ctl", ctl(), 32'b00000_00);
    check("post_rst_halted", 32'(halted), 32'd0);

    // Load-use single pulse: one bubble, PC and F/D held
    cyc();
    load_use_ID = 1'b1;
    settle();
    check("lu_ctl", ctl(), 32'b11000_01);
    cyc();
    load_use_ID = 1'b0;
    settle();
    check("lu_next_ctl", ctl(), 32'b00000_00);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Redirect during a 3-cycle imem miss: F/D cleared for 4 cycles
    do_reset();
    imem_stall  = 1'b1;
    redirect_EX = 1'b1;
    settle();
    check("rd_c1_ctl", ctl(), 32'b00000_11);
    cyc();
    redirect_EX = 1'b0;
    settle();
    check("rd_c2_ctl", ctl(), 32'b10000_10);
    check("rd_c2_state", 32'(state_dbg), 32'd1);
    check("rd_flush_cnt", 32'(flush_cnt), 32'd1);
    cyc();
    settle();
    check("rd_c3_ctl", ctl(), 32'b10000_10);
    cyc();
    imem_stall = 1'b0;
    settle();
    check("rd_c4_ctl", ctl(), 32'b00000_10);
    cyc();
    settle();
    check("rd_c5_ctl", ctl(), 32'b00000_00);
    check("rd_c5_state", 32'(state_dbg), 32'd0);
    check("rd_c5_flush", 32'(flush_cnt), 32'd1);
    check("rd_c5_stall", 32'(stall_cnt), 32'd2);

    // dmem stall masks a simultaneous redirect
    do_reset();
    dmem_stall  = 1'b1;
    redirect_EX = 1'b1;
    settle();
    check("dm_c1_ctl", ctl(), 32'b11111_00);
    cyc();
    settle();
    check("dm_c2_ctl", ctl(), 32'b11111_00);
    check("dm_c2_state", 32'(state_dbg), 32'd2);
    cyc();
    dmem_stall  = 1'b0;
    redirect_EX = 1'b0;
    settle();
    check("dm_fall_ctl", ctl(), 32'b00000_00);
    check("dm_flush_cnt", 32'(flush_cnt), 32'd0);
    cyc();
    settle();
    check("dm_after_state", 32'(state_dbg), 32'd0);

    // HALT decode, drain three cycles, retire, stay halted
    do_reset();
    halt_ID = 1'b1;
    settle();
    check("hl_id_ctl", ctl(), 32'b10000_10);
    cyc();
    halt_ID = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) halt_WB = 1'b1;
      settle();
      check($sformatf("hl_drain%0d_state", i), 32'(state_dbg), 32'd3);
      check($sformatf("hl_drain%0d_ctl", i), ctl(), 32'b10000_10);
      cyc();
    end
    halt_WB     = 1'b0;
    redirect_EX = 1'b1;
    imem_stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("hl_halted%0d", i), 32'(halted), 32'd1);
      check($sformatf("hl_halted%0d_ctl", i), ctl(), 32'b11111_00);
      check($sformatf("hl_halted%0d_state", i), 32'(state_dbg), 32'd4);
      cyc();
    end
    check("hl_flush_cnt", 32'(flush_cnt), 32'd0);
    check("hl_stall_cnt", 32'(stall_cnt), 32'd4);
    redirect_EX = 1'b0;
    imem_stall  = 1'b0;
    do_reset();
    settle();
    check("hl_rst_halted", 32'(halted), 32'd0);
    check("hl_rst_state", 32'(state_dbg), 32'd0);

    // 2^CNT_W + 5 stall cycles: counter saturates at 15 and holds
    imem_stall = 1'b1;
    for (int i = 0; i < 14; i++) cyc();
    settle();
    check("sat_14", 32'(stall_cnt), 32'd14);
    for (int i = 0; i < 7; i++) cyc();
    imem_stall = 1'b0;
    settle();
    check("sat_21", 32'(stall_cnt), 32'd15);
    cyc();
    cyc();
    settle();
    check("sat_hold", 32'(stall_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
